// File: rtl/ps2_scancode_decoder.sv
// PS/2 scancode set 2 decoder: folds E0/F0/E1 prefixes into key events,
// tracks shift/ctrl state and queues events in a small FIFO.
module ps2_scancode_decoder #(
    parameter int FIFO_AW = 3
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic [7:0] PS2_DATA,
    input  logic       PS2_VALID,
    input  logic       PS2_ERROR,
    output logic [7:0] EV_CODE,
    output logic       EV_EXT,
    output logic       EV_BREAK,
    output logic       EV_AVAIL,
    input  logic       EV_READ,
    output logic       SHIFT,
    output logic       CTRL,
    output logic       OVERFLOW,
    input  logic       OVF_CLR
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_E0,
        S_F0,
        S_E0F0,
        S_SKIP
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_skip;
    logic [2:0]         w_skip_nxt;
    logic               w_emit;
    logic               w_ext;
    logic               w_brk;
    logic               w_ctl;
    logic               w_fake;

    logic [3:0]         r_mod;
    logic [9:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW-1:0] w_rptr_nxt;
    logic [FIFO_AW:0]   r_count;
    logic [FIFO_AW:0]   w_left;
    logic [9:0]         r_head;
    logic               r_ovf;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [9:0]         w_wdata;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state <= S_IDLE;
            r_skip  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_skip  <= w_skip_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_skip_nxt  = r_skip;
        w_emit      = 1'b0;
        w_ext       = (r_state == S_E0) || (r_state == S_E0F0);
        w_brk       = (r_state == S_F0) || (r_state == S_E0F0);
        w_ctl       = PS2_DATA inside {8'h00, 8'hAA, 8'hFA, 8'hFC,
                                       8'hFD, 8'hFE, 8'hFF};
        w_fake      = w_ext && (PS2_DATA inside {8'h12, 8'h59});
        if (PS2_ERROR) begin
            w_state_nxt = S_IDLE;
            w_skip_nxt  = '0;
        end else if (PS2_VALID) begin
            if (r_state == S_SKIP) begin
                if (r_skip <= 3'd1) begin
                    w_state_nxt = S_IDLE;
                    w_skip_nxt  = '0;
                end else begin
                    w_skip_nxt = r_skip - 3'd1;
                end
            end else if (PS2_DATA == 8'hE0) begin
                w_state_nxt = S_E0;
            end else if (PS2_DATA == 8'hF0) begin
                w_state_nxt = w_ext ? S_E0F0 : S_F0;
            end else if (PS2_DATA == 8'hE1) begin
                // pause: drop the remaining seven bytes of the sequence
                w_state_nxt = S_SKIP;
                w_skip_nxt  = 3'd7;
            end else if (w_ctl || w_fake) begin
                w_state_nxt = S_IDLE;
            end else begin
                w_emit      = 1'b1;
                w_state_nxt = S_IDLE;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_mod <= '0;
        end else if (w_emit) begin
            if (!w_ext && PS2_DATA == 8'h12) r_mod[0] <= !w_brk;
            if (!w_ext && PS2_DATA == 8'h59) r_mod[1] <= !w_brk;
            if (!w_ext && PS2_DATA == 8'h14) r_mod[2] <= !w_brk;
            if (w_ext && PS2_DATA == 8'h14)  r_mod[3] <= !w_brk;
        end
    end

    assign w_full     = r_count == (FIFO_AW+1)'(DEPTH);
    assign w_pop      = EV_READ && (r_count != '0);
    assign w_push     = w_emit && (!w_full || w_pop);
    assign w_drop     = w_emit && w_full && !w_pop;
    assign w_wdata    = {w_ext, w_brk, PS2_DATA};
    assign w_rptr_nxt = w_pop ? r_rptr + 1'b1 : r_rptr;
    assign w_left     = w_pop ? r_count - 1'b1 : r_count;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_head  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_wdata;
                r_wptr        <= r_wptr + 1'b1;
            end
            r_rptr  <= w_rptr_nxt;
            r_count <= w_push ? w_left + 1'b1 : w_left;
            // head register holds its last value once the queue drains
            if (w_left != '0)
                r_head <= r_mem[w_rptr_nxt];
            else if (w_push)
                r_head <= w_wdata;
            if (w_drop)
                r_ovf <= 1'b1;
            else if (OVF_CLR)
                r_ovf <= 1'b0;
        end
    end

    assign EV_CODE  = r_head[7:0];
    assign EV_EXT   = r_head[9];
    assign EV_BREAK = r_head[8];
    assign EV_AVAIL = r_count != '0;
    assign SHIFT    = r_mod[0] | r_mod[1];
    assign CTRL     = r_mod[2] | r_mod[3];
    assign OVERFLOW = r_ovf;

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Sits directly downstream of the PS/2 byte receiver; consumes its one-cycle DATA/VALID/error strobes.
- Decodes scancode set 2 prefix sequences (E0 extended, F0 break, E1 pause) into single key events.
- Tracks shift/ctrl modifier state.
- Buffers events in a small FIFO for the keyboard-matrix/CPU side, with a pop handshake.

Parameters:
FIFO_AW, 3, log2 of event FIFO depth (depth = 2**FIFO_AW = 8)

Ports:
CLK  in  1  system clock
nRESET  in  1  reset; asynchronous, active-low
PS2_DATA  in  8  received byte, qualified by PS2_VALID
PS2_VALID  in  1  one-cycle strobe: PS2_DATA holds a good byte
PS2_ERROR  in  1  one-cycle strobe: parity/stop-bit error on the line
EV_CODE  out  8  scancode of FIFO head event
EV_EXT  out  1  head event was E0-prefixed
EV_BREAK  out  1  head event is a release (F0-prefixed)
EV_AVAIL  out  1  FIFO non-empty; EV_* valid
EV_READ  in  1  pop head event when EV_AVAIL=1
SHIFT  out  1  left (12) or right (59) shift held
CTRL  out  1  left (14) or right (E0 14) ctrl held
OVERFLOW  out  1  sticky: an event was dropped because the FIFO was full
OVF_CLR  in  1  clears OVERFLOW

Behaviour:
- Reset: all outputs 0; state IDLE; FIFO empty; skip counter 0; modifier bits 0. Reset mid-sequence discards all partial prefixes and queued events.
- Decoder states: IDLE, GOT_E0, GOT_F0, GOT_E0F0, SKIP. Bytes are processed only on cycles where PS2_VALID=1.
- Transitions on a valid byte:
  - E0 in any non-SKIP state -> GOT_E0 (a repeated or late prefix restarts the sequence).
  - F0 in IDLE or GOT_F0 -> GOT_F0.
  - F0 in GOT_E0 or GOT_E0F0 -> GOT_E0F0.
  - E1 in any non-SKIP state -> SKIP with skip counter = 7; the rest of the pause sequence is discarded. In SKIP, each byte decrements the counter; at 1 -> IDLE. No event is generated for pause.
  - Controller codes 00, AA, FA, FC, FD, FE, FF in any non-SKIP state -> discard, go to IDLE, no event.
  - Fake shifts: 12 or 59 in GOT_E0 or GOT_E0F0 -> discard, IDLE, no event.
  - Any other byte -> emit event {code=byte, ext=(state in GOT_E0, GOT_E0F0), brk=(state in GOT_F0, GOT_E0F0)}, then IDLE.
- PS2_ERROR=1: state -> IDLE and skip counter cleared, same cycle. If PS2_ERROR and PS2_VALID are both high, the error wins and the byte is ignored.
- Modifiers: four internal bits (Lshift, Rshift, Lctrl, Rctrl).
  - A bit sets on the make event for its key and clears on the break event.
  - Updated on every emitted event, including events dropped on overflow.
  - Registered; SHIFT/CTRL change the cycle after the final byte's PS2_VALID.
  - Keys: Lshift = code 12 non-ext; Rshift = 59 non-ext; Lctrl = 14 non-ext; Rctrl = 14 ext.
- FIFO: 10-bit entries, registered storage, read/write pointers FIFO_AW bits wide (natural wrap), count FIFO_AW+1 bits.
  - Latency: for the final byte's PS2_VALID at cycle N with the FIFO empty, EV_AVAIL=1 and EV_* valid at N+1.
  - EV_READ with EV_AVAIL=1 pops the head; the next entry (or EV_AVAIL=0) appears the following cycle.
  - EV_READ with EV_AVAIL=0 is ignored.
  - Push and pop in the same cycle: both happen, count unchanged. This includes the full case, where the push is accepted because a slot frees that cycle.
  - Push when full with no pop: the event is dropped, FIFO unchanged, OVERFLOW set.
  - OVERFLOW stays 1 until an OVF_CLR cycle. If set and clear occur in the same cycle, set wins.
  - When EV_AVAIL=0, EV_CODE/EV_EXT/EV_BREAK hold their last value; consumers ignore them.

Test Plan:
- Bytes 1C; F0 1C -> two events {1C, ext0, brk0}, {1C, ext0, brk1}. First EV_AVAIL appears one cycle after the 1C strobe.
- Bytes E0 75; E0 F0 75 -> events {75, 1, 0}, {75, 1, 1}. Bytes E0 12 E0 7C -> single event {7C, 1, 0}; fake shift dropped, SHIFT stays 0.
- Bytes E1 14 77 E1 F0 14 F0 77 then 29 -> only event {29, 0, 0}. Bytes AA and FA alone -> no events.
- Bytes 12, E0 14 -> SHIFT=1, CTRL=1. Then F0 12 -> SHIFT=0. Then E0 F0 14 -> CTRL=0.
- 9 make codes (15..1D) with no reads -> EV_AVAIL=1, 8 entries 15..1C, OVERFLOW=1. With the FIFO full, EV_READ on the same cycle as the next event -> event accepted, OVERFLOW unchanged. OVF_CLR -> OVERFLOW=0.
- Bytes E0 F0, then PS2_ERROR, then 1C -> event {1C, 0, 0}. nRESET pulsed with 3 events queued -> EV_AVAIL=0 immediately (asynchronously); SHIFT, CTRL and OVERFLOW read 0.
